alu181_nibble_seq: RTL and testbench

Multi-cycle, WIDTH-bit successor of the 4-bit 74181 ALU. The block registers WIDTH-bit operands and sequences them through a single 74181-equivalent 4-bit slice, one nibble per cycle, LSB first. It carries the ripple carry and the equality term between cycles. Results return over a valid/ready handshake, and the block sits behind the user-project register interface as a shared arithmetic/logic engine.

---
 rtl/alu181_pkg.sv | 33 +++
 rtl/alu181_nibble_seq_if.sv | 33 +++
 rtl/alu181_slice.sv | 41 ++++
 rtl/alu181_nibble_seq.sv | 141 ++++++++++++++
 tb/tb_alu181_nibble_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/alu181_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu181_pkg: shared types, 74181 function codes and index-width helpers      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package alu181_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Active-high-data 74181 select codes; XOR and AND are logic-mode (m = 1)
  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0110;
  localparam logic [3:0] S_XOR = 4'b0110;
  localparam logic [3:0] S_AND = 4'b1011;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A single-nibble build still needs a one-bit index register
  function automatic int idx_width(input int nib);
    return (nib > 1) ? clog2(nib) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu181_nibble_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu181_nibble_seq_if: command/result handshake bus of the nibble ALU        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface alu181_nibble_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             cn_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             aeb;
  logic             cn4_b;
  logic             ovf;

  modport master (
    output in_valid, a, b, s, m, cn_b, out_ready,
    input  in_ready, out_valid, f, aeb, cn4_b, ovf
  );

  modport slave (
    input  in_valid, a, b, s, m, cn_b, out_ready,
    output in_ready, out_valid, f, aeb, cn4_b, ovf
  );
endinterface
`default_nettype wire

// File: rtl/alu181_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu181_slice: combinational 4-bit 74181 core (active-high data)             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu181_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn_b,
  output logic [3:0] f,
  output logic       cn4_b,
  output logic       c3
);
  logic [3:0] e;
  logic [3:0] d;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    e = ~((a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}}));
    d = ~((~b & {4{s[1]}}) | (b & {4{s[0]}}) | a);
    // ~E is the bit generate and ~D the bit propagate of the internal adder
    g = ~e;
    p = ~d;
    c[0] = ~cn_b;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    f = e ^ d ^ (c[3:0] | {4{m}});
  end

  assign cn4_b = ~c[4];
  assign c3    = c[3];

endmodule
`default_nettype wire

// File: rtl/alu181_nibble_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu181_nibble_seq: WIDTH-bit ALU sequencing one 74181 slice, LSB nibble     |
// | first. Define ALU181_OVF_EN to enable the signed-overflow output.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu181_nibble_seq
  import alu181_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  alu181_nibble_seq_if.slave   bus
);
  localparam int              NIB    = WIDTH / 4;
  localparam int              KW     = idx_width(NIB);
  localparam logic [KW-1:0]   K_LAST = KW'(NIB - 1);

  state_t           state;
  state_t           state_nx;
  logic             in_ready_w;
  logic             out_valid_w;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] f_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             c_b_q;
  logic             aeb_q;
  logic [KW-1:0]    k_q;

  logic [3:0]       nib_f;
  logic             nib_cn4b;
  logic             nib_c3;

  assign accept = (state == ST_IDLE) && bus.in_valid;
  assign last   = (k_q == K_LAST);

  // Operands shift down a nibble per cycle so the slice always sees bits [3:0]
  alu181_slice u_slice (
    .a     (a_q[3:0]),
    .b     (b_q[3:0]),
    .s     (s_q),
    .m     (m_q),
    .cn_b  (c_b_q),
    .f     (nib_f),
    .cn4_b (nib_cn4b),
    .c3    (nib_c3)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    in_ready_w  = 1'b0;
    out_valid_w = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready_w = 1'b1;
        if (bus.in_valid) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid_w = 1'b1;
        if (bus.out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_w & ~wb_rst_i;
  assign bus.out_valid = out_valid_w;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      f_q   <= '0;
      s_q   <= 4'd0;
      m_q   <= 1'b0;
      c_b_q <= 1'b1;
      aeb_q <= 1'b0;
      k_q   <= '0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      s_q   <= bus.s;
      m_q   <= bus.m;
      c_b_q <= bus.cn_b;
      aeb_q <= 1'b1;
      k_q   <= '0;
    end else if (state == ST_RUN) begin
      a_q                  <= a_q >> 4;
      b_q                  <= b_q >> 4;
      f_q[{k_q, 2'b00} +: 4] <= nib_f;
      c_b_q                <= nib_cn4b;
      aeb_q                <= aeb_q & (&nib_f);
      k_q                  <= k_q + KW'(1);
    end
  end

  assign bus.f     = f_q;
  assign bus.aeb   = aeb_q;
  assign bus.cn4_b = c_b_q;

`ifdef ALU181_OVF_EN
  logic ovf_q;

  // Overflow is carry into the MSB xor carry out of it, taken on the top nibble
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if ((state == ST_RUN) && last) begin
      ovf_q <= ~m_q & (nib_c3 ^ ~nib_cn4b);
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic c3_unused;

  assign c3_unused = nib_c3;
  assign bus.ovf   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu181_nibble_seq.sv
`default_nettype none
// Bench for alu181_nibble_seq: word-level reference model, per-cycle compare
// process, directed literal vectors and randomized commands.
module tb_alu181_nibble_seq;
  import alu181_pkg::*;

  localparam int W   = 16;
  localparam int NIB = W / 4;
`ifdef ALU181_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu181_nibble_seq_if #(.WIDTH(W)) bus ();

  alu181_nibble_seq #(.WIDTH(W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 74181 as X + Y + cin on the full word: X = A | B&S0 | ~B&S1, Y = A&B&S3 | A&~B&S2;
  // logic mode gives ~(X ^ Y). Returns {ovf, cn4_b, aeb, f}.
  function automatic logic [W+3:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] s, input logic m, input logic cnb);
    logic [W:0]   x, y, sum, lo;
    logic [W-1:0] f;
    logic         cin, ovf;
    x   = {1'b0, a | (b & {W{s[0]}}) | (~b & {W{s[1]}})};
    y   = {1'b0, (a & b & {W{s[3]}}) | (a & ~b & {W{s[2]}})};
    cin = ~cnb;
    sum = x + y + {{W{1'b0}}, cin};
    lo  = {2'b00, x[W-2:0]} + {2'b00, y[W-2:0]} + {{W{1'b0}}, cin};
    f   = m ? ~(x[W-1:0] ^ y[W-1:0]) : sum[W-1:0];
    ovf = (OVF_EN && !m) ? (lo[W-1] ^ sum[W]) : 1'b0;
    return {ovf, ~sum[W], &f, f};
  endfunction

  // Transaction-level model: idle / counting down NIB cycles / holding a result
  logic           m_idle  = 1'b1;
  logic           m_valid = 1'b0;
  logic           m_rstv  = 1'b0;
  int             m_cnt   = 0;
  logic [W+3:0]   m_res   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_rstv  <= 1'b1;
      m_cnt   <= 0;
    end else if (m_idle) begin
      if (bus.in_valid) begin
        m_idle <= 1'b0;
        m_rstv <= 1'b0;
        m_cnt  <= NIB;
        m_res  <= ref_alu(bus.a, bus.b, bus.s, bus.m, bus.cn_b);
      end
    end else if (!m_valid) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_valid <= 1'b1;
    end else if (bus.out_ready) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(posedge clk);
      #1;
      chk("in_ready", bus.in_ready, m_idle && !rst);
      chk("out_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        chk("f", bus.f, m_res[W-1:0]);
        chk("aeb", bus.aeb, m_res[W]);
        chk("cn4_b", bus.cn4_b, m_res[W+1]);
        chk("ovf", bus.ovf, m_res[W+2]);
      end
      if (m_rstv) begin
        chk("rst_f", bus.f, 0);
        chk("rst_aeb", bus.aeb, 0);
        chk("rst_cn4_b", bus.cn4_b, 1);
        chk("rst_ovf", bus.ovf, 0);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the handshake
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [3:0] is,
                       input logic im, input logic icnb, input int hold,
                       output logic [W-1:0] rf, output logic raeb, output logic rcn,
                       output logic rovf, output int lat);
    bus.a = ia; bus.b = ib; bus.s = is; bus.m = im; bus.cn_b = icnb;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.s = 4'($urandom);
    bus.m = 1'($urandom); bus.cn_b = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      tests++;
      fails++;
      $display("FAIL out_valid_timeout: actual 0 required 1 at %0t", $time);
    end
    rf = bus.f; raeb = bus.aeb; rcn = bus.cn4_b; rovf = bus.ovf;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a = W'($urandom); bus.b = W'($urandom);
      @(negedge clk);
      chk("bp_f_stable", bus.f, rf);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  logic [W-1:0] rf;
  logic         raeb, rcn, rovf;
  int           lat;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.s = 4'd0; bus.m = 1'b0; bus.cn_b = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready_forced", bus.in_ready, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_f", bus.f, 0);
    chk("reset_cn4_b", bus.cn4_b, 1);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", bus.in_ready, 1);
    @(negedge clk);

    issue(16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1, 0, rf, raeb, rcn, rovf, lat);
    chk("add_wrap_f", rf, 16'h0000);
    chk("add_wrap_cn4_b", rcn, 0);
    chk("add_wrap_aeb", raeb, 0);
    chk("add_wrap_latency", lat, NIB);

    issue(16'h5A5A, 16'h5A5A, S_SUB, 1'b0, 1'b1, 0, rf, raeb, rcn, rovf, lat);
    chk("sub_eq_f", rf, 16'hFFFF);
    chk("sub_eq_aeb", raeb, 1);

    issue(16'h1234, 16'h00FF, S_XOR, 1'b1, 1'b0, 0, rf, raeb, rcn, rovf, lat);
    chk("xor_cin0_f", rf, 16'h12CB);
    issue(16'h1234, 16'h00FF, S_XOR, 1'b1, 1'b1, 0, rf, raeb, rcn, rovf, lat);
    chk("xor_cin1_f", rf, 16'h12CB);

    issue(16'hF0F0, 16'h3C3C, S_AND, 1'b1, 1'b1, 1, rf, raeb, rcn, rovf, lat);
    chk("and_f", rf, 16'h3030);

    issue(16'h7FFF, 16'h0001, S_ADD, 1'b0, 1'b1, 3, rf, raeb, rcn, rovf, lat);
    chk("ovf_f", rf, 16'h8000);
    chk("ovf_flag", rovf, OVF_EN ? 1 : 0);
    #1;
    chk("after_hs_in_ready", bus.in_ready, 1);

    // Abort a command while nibble 2 is in flight
    bus.a = 16'hABCD; bus.b = 16'h1111; bus.s = S_ADD; bus.m = 1'b0; bus.cn_b = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_f", bus.f, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    @(negedge clk);
    issue(16'h0003, 16'h0004, S_ADD, 1'b0, 1'b1, 0, rf, raeb, rcn, rovf, lat);
    chk("post_abort_add_f", rf, 16'h0007);

    for (int n = 0; n < 200; n++) begin
      issue(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 2), rf, raeb, rcn, rovf, lat);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
